// File: rtl/warp_fetch_decode_unit_if.sv
// Bundle between the fetch/decode unit and its warps, instruction memory
// and the downstream decode consumer.
interface warp_fetch_decode_unit_if #(
  parameter int NumWarps   = 8,
  parameter int WarpWidth  = 32,
  parameter int PcWidth    = 32,
  parameter int InstrWidth = 32
);
  localparam int SubwarpIdW = (WarpWidth > 1) ? $clog2(WarpWidth) : 1;
  localparam int WarpIdW    = (NumWarps > 1) ? $clog2(NumWarps) : 1;

  logic [NumWarps-1:0]            ready_for_fetch_i;
  logic [NumWarps*PcWidth-1:0]    fetch_pc_i;
  logic [NumWarps*WarpWidth-1:0]  fetch_act_mask_i;
  logic [NumWarps*SubwarpIdW-1:0] fetch_subwarp_id_i;
  logic [NumWarps-1:0]            selected_for_fetch_o;

  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [PcWidth-1:0]    imem_req_pc_o;
  logic                  imem_rsp_valid_i;
  logic                  imem_rsp_ready_o;
  logic [InstrWidth-1:0] imem_rsp_data_i;

  logic                  dec_valid_o;
  logic                  dec_ready_i;
  logic [InstrWidth-1:0] dec_instr_o;
  logic [PcWidth-1:0]    dec_pc_o;
  logic [WarpWidth-1:0]  dec_act_mask_o;
  logic [WarpIdW-1:0]    dec_warp_id_o;

  logic [NumWarps-1:0]   instruction_decoded_o;
  logic                  is_branch_o;
  logic [SubwarpIdW-1:0] decoded_subwarp_id_o;
  logic [PcWidth-1:0]    next_pc_o;

  modport master (
    input  ready_for_fetch_i, fetch_pc_i,
    input  fetch_act_mask_i, fetch_subwarp_id_i,
    output selected_for_fetch_o,
    output imem_req_valid_o, imem_req_pc_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i, imem_rsp_data_i,
    output imem_rsp_ready_o,
    output dec_valid_o, dec_instr_o, dec_pc_o,
    output dec_act_mask_o, dec_warp_id_o,
    input  dec_ready_i,
    output instruction_decoded_o, is_branch_o,
    output decoded_subwarp_id_o, next_pc_o
  );

  modport slave (
    output ready_for_fetch_i, fetch_pc_i,
    output fetch_act_mask_i, fetch_subwarp_id_i,
    input  selected_for_fetch_o,
    input  imem_req_valid_o, imem_req_pc_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i, imem_rsp_data_i,
    input  imem_rsp_ready_o,
    input  dec_valid_o, dec_instr_o, dec_pc_o,
    input  dec_act_mask_o, dec_warp_id_o,
    output dec_ready_i,
    input  instruction_decoded_o, is_branch_o,
    input  decoded_subwarp_id_o, next_pc_o
  );
endinterface

// File: rtl/warp_fetch_decode_unit.sv
// Round-robin warp fetcher with in-order in-flight queue and a single
// decode register that reports next PC / branch back to the owning warp.
module warp_fetch_decode_unit #(
  parameter int NumWarps   = 8,
  parameter int WarpWidth  = 32,
  parameter int PcWidth    = 32,
  parameter int InstrWidth = 32,
  parameter int FifoDepth  = 4
) (
  input logic clk_i,
  input logic rst_i,
  warp_fetch_decode_unit_if.master bus
);
  localparam int SubW = (WarpWidth > 1) ? $clog2(WarpWidth) : 1;
  localparam int WidW = (NumWarps > 1) ? $clog2(NumWarps) : 1;
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic [WidW-1:0]      warp;
    logic [SubW-1:0]      sub;
    logic [PcWidth-1:0]   pc;
    logic [WarpWidth-1:0] mask;
  } fq_t;

  fq_t             q [FifoDepth];
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [CntW-1:0] count;
  logic [WidW-1:0] rr;

  logic                  dec_valid;
  logic [InstrWidth-1:0] dec_instr;
  logic [PcWidth-1:0]    dec_pc;
  logic [WarpWidth-1:0]  dec_mask;
  logic [WidW-1:0]       dec_warp;
  logic [SubW-1:0]       dec_sub;

  logic [WidW-1:0] win;
  logic            any;
  logic            full;
  logic            req_valid;
  logic            req_hs;
  logic            rsp_ready;
  logic            pop;
  logic            fire;
  fq_t             entry;

  // First ready warp at or after the round-robin pointer
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int i = 0; i < NumWarps; i++) begin
      idx = (int'(rr) + i) % NumWarps;
      if (!any && bus.ready_for_fetch_i[idx]) begin
        any = 1'b1;
        win = WidW'(idx);
      end
    end
  end

  assign full      = (count == CntW'(FifoDepth));
  assign req_valid = any & ~full & ~rst_i;
  assign req_hs    = req_valid & bus.imem_req_ready_i;
  assign rsp_ready = ~dec_valid | bus.dec_ready_i;
  assign pop       = bus.imem_rsp_valid_i & rsp_ready & (count != '0);
  assign fire      = dec_valid & bus.dec_ready_i;

  assign entry.warp = win;
  assign entry.sub  = bus.fetch_subwarp_id_i[int'(win)*SubW +: SubW];
  assign entry.pc   = bus.fetch_pc_i[int'(win)*PcWidth +: PcWidth];
  assign entry.mask = bus.fetch_act_mask_i[int'(win)*WarpWidth +: WarpWidth];

  assign bus.imem_req_valid_o     = req_valid;
  assign bus.imem_req_pc_o        = req_valid ? entry.pc : '0;
  assign bus.selected_for_fetch_o = req_hs ? (NumWarps'(1) << win) : '0;
  assign bus.imem_rsp_ready_o     = rsp_ready;

  always_ff @(posedge clk_i) begin
    if (req_hs) q[tail] <= entry;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      rr        <= '0;
      dec_valid <= 1'b0;
      dec_instr <= '0;
      dec_pc    <= '0;
      dec_mask  <= '0;
      dec_warp  <= '0;
      dec_sub   <= '0;
    end else begin
      if (req_hs) begin
        tail <= (tail == PtrW'(FifoDepth - 1)) ? '0 : tail + 1'b1;
        rr   <= (win == WidW'(NumWarps - 1)) ? '0 : win + 1'b1;
      end
      // Responses with nothing in flight are accepted and dropped
      if (pop) begin
        head      <= (head == PtrW'(FifoDepth - 1)) ? '0 : head + 1'b1;
        dec_valid <= 1'b1;
        dec_instr <= bus.imem_rsp_data_i;
        dec_pc    <= q[head].pc;
        dec_mask  <= q[head].mask;
        dec_warp  <= q[head].warp;
        dec_sub   <= q[head].sub;
      end else if (fire) begin
        dec_valid <= 1'b0;
      end
      unique case ({req_hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  logic [6:0]         opcode;
  logic               is_br;
  logic [PcWidth-1:0] imm;
  logic [PcWidth-1:0] npc;

  assign opcode = dec_instr[6:0];
  assign is_br  = (opcode == 7'h63) | (opcode == 7'h6F) | (opcode == 7'h67);
  assign imm    = {{(PcWidth-12){dec_instr[31]}}, dec_instr[31:20]};
  assign npc    = is_br ? dec_pc + imm : dec_pc + PcWidth'(4);

  assign bus.dec_valid_o    = dec_valid;
  assign bus.dec_instr_o    = dec_instr;
  assign bus.dec_pc_o       = dec_pc;
  assign bus.dec_act_mask_o = dec_mask;
  assign bus.dec_warp_id_o  = dec_warp;

  assign bus.instruction_decoded_o = fire ? (NumWarps'(1) << dec_warp) : '0;
  assign bus.is_branch_o           = fire & is_br;
  assign bus.decoded_subwarp_id_o  = fire ? dec_sub : '0;
  assign bus.next_pc_o             = fire ? npc : '0;
endmodule
